// File: rtl/mux_arb_reg.sv
// mux_arb_reg: N:1 arbitrating multiplexer with a registered single-entry output stage.
// DEPTH valid/ready producers share one BIT_WIDTH output. Each cycle one channel is
// granted by round-robin (ARB_MODE=0) or fixed priority (ARB_MODE=1, lowest index).
// The winner is loaded into the output register with valid/ready backpressure.
// The output stage reloads in the same cycle it drains, so it sustains full throughput.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    DEPTH packed channels; channel i at [BIT_WIDTH*i +: BIT_WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit high)
//   out_data   registered winning data
//   out_sel    index of the channel that produced out_data
//   out_valid  output stage holds a beat
//   out_ready  downstream accepts the beat
module mux_arb_reg #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SEL_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned ARB_MODE  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [BIT_WIDTH*DEPTH-1:0] in_data,
    input  logic [DEPTH-1:0]           in_valid,
    output logic [DEPTH-1:0]           in_ready,
    output logic [BIT_WIDTH-1:0]       out_data,
    output logic [SEL_WIDTH-1:0]       out_sel,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int DEPTH_I = int'(DEPTH);

    logic [BIT_WIDTH-1:0] ch_data [DEPTH];
    logic [SEL_WIDTH-1:0] ptr;
    logic [SEL_WIDTH-1:0] ptr_nxt;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic [DEPTH-1:0]     grant;
    logic                 grant_found;
    logic                 load_en;
    logic                 xfer;

    // Unpack the flat input bus into per-channel words
    for (genvar g = 0; g < DEPTH_I; g++) begin : g_unpack
        assign ch_data[g] = in_data[BIT_WIDTH*g +: BIT_WIDTH];
    end

    // Output stage can take a beat when empty or when its current beat drains
    assign load_en = ~out_valid | out_ready;

    // Grant: first valid channel scanning upward from the start index, wrapping at DEPTH
    always_comb begin
        int                   idx;
        logic [SEL_WIDTH-1:0] cand;
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < DEPTH_I; k++) begin
            idx = (ARB_MODE == 0) ? int'(ptr) + k : k;
            if (idx >= DEPTH_I) begin
                idx = idx - DEPTH_I;
            end
            cand = SEL_WIDTH'(idx);
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign in_ready = grant & {DEPTH{load_en}};
    assign xfer     = grant_found & load_en;

    // Pointer moves past the winner; explicit wrap keeps non-power-of-two DEPTH in range
    assign ptr_nxt = (grant_idx == SEL_WIDTH'(DEPTH - 1)) ? '0 : grant_idx + SEL_WIDTH'(1);

    // Output stage and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant_idx];
                out_sel   <= grant_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer && (ARB_MODE == 0)) begin
                ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Testbench for mux_arb_reg: three instances (RR DEPTH=4, FP DEPTH=4, RR DEPTH=3)
// driven in parallel, each checked against a behavioural arbiter model and a
// scoreboard of expected {sel,data} beats popped when the DUT hands a beat off.
module tb_mux_arb_reg;

    logic clk;
    logic rst_n;

    // Per-instance stimulus and observation (index 0: RR4, 1: FP4, 2: RR3)
    logic [31:0] idat [3];
    logic [3:0]  iv   [3];
    logic        ordy [3];
    logic [3:0]  irq  [3];
    logic [7:0]  od   [3];
    logic [1:0]  os   [3];
    logic        ov   [3];
    logic [3:0]  ir_rr4;
    logic [3:0]  ir_fp4;
    logic [2:0]  ir_rr3;

    int checks = 0;
    int errors = 0;

    // Model state
    logic        mv   [3];
    int          mptr [3];
    int unsigned exp_q [3][$];

    mux_arb_reg #(.BIT_WIDTH(8), .DEPTH(4), .ARB_MODE(0)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_data(idat[0]), .in_valid(iv[0]), .in_ready(ir_rr4),
        .out_data(od[0]), .out_sel(os[0]), .out_valid(ov[0]), .out_ready(ordy[0]));

    mux_arb_reg #(.BIT_WIDTH(8), .DEPTH(4), .ARB_MODE(1)) u_fp4 (
        .clk(clk), .rst_n(rst_n), .in_data(idat[1]), .in_valid(iv[1]), .in_ready(ir_fp4),
        .out_data(od[1]), .out_sel(os[1]), .out_valid(ov[1]), .out_ready(ordy[1]));

    mux_arb_reg #(.BIT_WIDTH(8), .DEPTH(3), .ARB_MODE(0)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .in_data(idat[2][23:0]), .in_valid(iv[2][2:0]), .in_ready(ir_rr3),
        .out_data(od[2]), .out_sel(os[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

    assign irq[0] = ir_rr4;
    assign irq[1] = ir_fp4;
    assign irq[2] = {1'b0, ir_rr3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference arbiter: returns granted channel or -1
    function automatic int pick(logic [3:0] v, int p, int depth, int mode);
        for (int k = 0; k < depth; k++) begin
            int i;
            i = (mode == 1) ? k : (p + k) % depth;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Model + scoreboard, evaluated mid-cycle while inputs are stable
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int          depth;
            int          mode;
            int          p;
            logic        le;
            logic [3:0]  exp_ir;
            int unsigned e;
            depth = (d == 2) ? 3 : 4;
            mode  = (d == 1) ? 1 : 0;
            if (!rst_n) begin
                check($sformatf("d%0d_rst_valid", d), 32'(ov[d]), 32'd0);
                check($sformatf("d%0d_rst_data", d), 32'(od[d]), 32'd0);
                check($sformatf("d%0d_rst_sel", d), 32'(os[d]), 32'd0);
                mv[d]   = 1'b0;
                mptr[d] = 0;
                exp_q[d].delete();
            end else begin
                check($sformatf("d%0d_out_valid", d), 32'(ov[d]), 32'(mv[d]));
                if (ov[d]) check($sformatf("d%0d_sel_range", d), 32'(int'(os[d]) < depth), 32'd1);
                if (mv[d] && ordy[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check($sformatf("d%0d_sb_underflow", d), 32'd1, 32'd0);
                    end else begin
                        e = exp_q[d].pop_front();
                        check($sformatf("d%0d_beat", d), {22'd0, os[d], od[d]}, e);
                    end
                end
                le     = !mv[d] || ordy[d];
                p      = pick(iv[d], mptr[d], depth, mode);
                exp_ir = (le && p >= 0) ? 4'(1 << p) : 4'd0;
                check($sformatf("d%0d_in_ready", d), 32'(irq[d]), 32'(exp_ir));
                if (le && p >= 0) begin
                    exp_q[d].push_back((32'(p) << 8) | ((idat[d] >> (8 * p)) & 32'hFF));
                    mptr[d] = (mode == 1) ? 0 : (p + 1) % depth;
                    mv[d]   = 1'b1;
                end else if (ordy[d]) begin
                    mv[d] = 1'b0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_all(input logic [3:0] v, input logic r);
        for (int d = 0; d < 3; d++) begin
            iv[d]   = (d == 2) ? (v & 4'b0111) : v;
            ordy[d] = r;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        idat[0] = 32'hA3A2A1A0;
        idat[1] = 32'hB3B2B1B0;
        idat[2] = 32'h00C2C1C0;
        for (int d = 0; d < 3; d++) begin
            mv[d]   = 1'b0;
            mptr[d] = 0;
        end
        set_all(4'b1111, 1'b1);

        // Reset held with all inputs valid
        cyc(3);
        rst_n = 1'b1;

        // Round-robin fairness with fixed distinct data
        cyc(10);

        // Backpressure stall, then release with no bubble
        set_all(4'b1111, 1'b0);
        cyc(3);
        set_all(4'b1111, 1'b1);
        cyc(4);

        // Fixed priority pattern 1010 then drop ch1; RR3 sees 101
        iv[0] = 4'b1010;
        iv[1] = 4'b1010;
        iv[2] = 4'b0101;
        cyc(4);
        iv[1] = 4'b1000;
        cyc(3);

        // Randomised traffic with per-channel valid churn and backpressure
        for (int c = 0; c < 60; c++) begin
            for (int d = 0; d < 3; d++) begin
                idat[d] = $urandom;
                iv[d]   = 4'($urandom) & ((d == 2) ? 4'b0111 : 4'b1111);
                ordy[d] = ($urandom_range(3) != 0);
            end
            cyc(1);
        end

        // Async reset mid-stream: out_valid must drop without a clock edge
        set_all(4'b1111, 1'b1);
        cyc(2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d_async_rst", d), 32'(ov[d]), 32'd0);
        end
        cyc(2);
        rst_n = 1'b1;
        iv[2] = 4'b0110;
        cyc(6);

        // Drain and confirm every expected beat was delivered
        set_all(4'b0000, 1'b1);
        cyc(3);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d_sb_empty", d), 32'(exp_q[d].size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
